// File: rtl/regfile_dumper_pkg.sv
// Shared types and constants for the register-file dumper: FSM states, header nibble, byte-count helper.
package regfile_dumper_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_SEND,
    ST_FIN
  } state_t;

  localparam logic [3:0] DUMP_HDR = 4'hA;
  localparam int unsigned NUM_REGS = 16;

  // Bytes needed to carry a w-bit word.
  function automatic int unsigned nbytes(input int unsigned w);
    return (w + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Loads one word and emits it LSB-first as bytes over valid/ready; last_c flags the final byte.
module byte_serializer
  import regfile_dumper_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] word,
  input  logic             ready,
  output logic             valid,
  output logic [7:0]       data,
  output logic             last_c
);

  localparam int unsigned NB = nbytes(WIDTH);
  localparam int unsigned SW = NB * 8;
  localparam int unsigned CW = $clog2(NB + 1);

  logic [SW-1:0] shreg;
  logic [CW-1:0] cnt;

  // Zero-extension on load leaves the unused top bits of the last byte at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else if (load && !valid) begin
      shreg <= SW'(word);
      cnt   <= CW'(NB);
      valid <= 1'b1;
    end else if (valid && ready) begin
      shreg <= shreg >> 8;
      cnt   <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        valid <= 1'b0;
      end
    end
  end

  assign data   = shreg[7:0];
  assign last_c = valid && (cnt == CW'(1));

endmodule

// File: rtl/regfile_dumper.sv
// Walks all 16 regfile addresses on request and streams each value out as bytes over valid/ready.
// Optional feature: define DUMP_HEADER_EN to prefix each register with header byte {DUMP_HDR, addr}.
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned READ_LAT = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [3:0]       ra,
  input  logic [WIDTH-1:0] rd,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             done
);

`ifdef DUMP_HEADER_EN
  localparam int unsigned SER_W = WIDTH + 8;
`else
  localparam int unsigned SER_W = WIDTH;
`endif

  state_t           state;
  logic [3:0]       addr;
  logic             load_c;
  logic             last_c;
  logic [SER_W-1:0] word_c;

  assign ra = addr;

  // Capture happens on the edge that leaves ADDR (combinational port) or WAIT (registered port).
  assign load_c = (state == ST_WAIT) || ((state == ST_ADDR) && (READ_LAT == 0));

`ifdef DUMP_HEADER_EN
  assign word_c = {rd, DUMP_HDR, addr};
`else
  assign word_c = rd;
`endif

  byte_serializer #(
    .WIDTH (SER_W)
  ) u_ser (
    .clk    (clk),
    .reset  (reset),
    .load   (load_c),
    .word   (word_c),
    .ready  (tx_ready),
    .valid  (tx_valid),
    .data   (tx_data),
    .last_c (last_c)
  );

  // Sequencer: address counter, read-latency wait and done/busy generation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= 4'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_ADDR;
            addr  <= 4'd0;
            busy  <= 1'b1;
          end
        end
        ST_ADDR: begin
          state <= (READ_LAT == 0) ? ST_SEND : ST_WAIT;
        end
        ST_WAIT: begin
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_valid && tx_ready && last_c) begin
            if (addr == 4'(NUM_REGS - 1)) begin
              state <= ST_FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ST_ADDR;
              addr  <= addr + 4'd1;
            end
          end
        end
        ST_FIN: begin
          // A new request is already accepted in the done cycle.
          if (start) begin
            state <= ST_ADDR;
            addr  <= 4'd0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
